// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and helpers for the truth-table sequencer
// Contents:
//   tt_state_e : FSM state encoding (IDLE, APPLY, SAMPLE, DONE)
//   n_vec      : number of input vectors for an n-input block (1 << n)
//   sat_inc    : saturating increment against an explicit ceiling
package tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

    function automatic int n_vec(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_val);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/tt_step_timer.sv
// rtl/tt_step_timer.sv - hold counter and vector counter for the sweep
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clr         : zero both counters (sweep start / sweep end)
//   hold_en     : count settle cycles (FSM in APPLY)
//   advance     : step to the next vector and restart the hold count
//   vec         : current stimulus vector
//   sample_now  : last settle cycle of the current vector
//   last_vec    : current vector is all-ones
module tt_step_timer #(
    parameter int N_IN = 2,
    parameter int HOLD = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            hold_en,
    input  logic            advance,
    output logic [N_IN-1:0] vec,
    output logic            sample_now,
    output logic            last_vec
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [HW-1:0] hold_cnt;

    assign sample_now = hold_en && (hold_cnt == HW'(HOLD - 1));
    assign last_vec   = &vec;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hold_cnt <= '0;
            vec      <= '0;
        end else if (advance) begin
            hold_cnt <= '0;
            vec      <= vec + N_IN'(1);
        end else if (hold_en && !sample_now) begin
            // Stop at HOLD-1 so the counter never wraps while waiting.
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps all input vectors, captures two truth tables, counts mismatches
// Optional feature macro: TT_FIRST_FAIL_EN (adds first_fail_vld / first_fail_vec)
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start           : begin a sweep (honoured only when idle)
//   cmp_mode        : 0 compares dut_a vs dut_b, 1 compares dut_a vs exp_tt
//   exp_tt          : golden table for dut_a, bit i = expected a at vector i
//   dut_a, dut_b    : outputs of the two implementations under test
//   vec_out         : stimulus vector, MSB is the first DUT input
//   busy            : high from the first APPLY cycle through DONE
//   done            : one-cycle pulse at sweep end
//   pass            : no mismatches in the last sweep
//   err_cnt         : saturating mismatch count for the current sweep
//   tt_a, tt_b      : captured truth tables
//   first_fail_vld  : (TT_FIRST_FAIL_EN) a mismatch has been seen this sweep
//   first_fail_vec  : (TT_FIRST_FAIL_EN) vector of the first mismatch
module truth_table_sequencer
    import tt_pkg::*;
#(
    parameter  int N_IN  = 2,
    parameter  int HOLD  = 1,
    parameter  int CNT_W = 8,
    localparam int NV    = n_vec(N_IN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmp_mode,
    input  logic [NV-1:0]    exp_tt,
    input  logic             dut_a,
    input  logic             dut_b,
    output logic [N_IN-1:0]  vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
`ifdef TT_FIRST_FAIL_EN
    output logic             first_fail_vld,
    output logic [N_IN-1:0]  first_fail_vec,
`endif
    output logic [NV-1:0]    tt_a,
    output logic [NV-1:0]    tt_b
);

    localparam logic [31:0] ERR_MAX = (32'd1 << CNT_W) - 32'd1;

    tt_state_e        state;
    logic             sample_now;
    logic             last_vec;
    logic             clr;
    logic             hold_en;
    logic             advance;
    logic             mismatch;
    logic [CNT_W-1:0] err_next;
    logic [CNT_W-1:0] err_after;

    assign clr     = ((state == ST_IDLE) && start) || (state == ST_DONE);
    assign hold_en = (state == ST_APPLY);
    assign advance = (state == ST_SAMPLE) && !last_vec;

    assign mismatch  = cmp_mode ? (dut_a != exp_tt[vec_out]) : (dut_a != dut_b);
    assign err_next  = CNT_W'(sat_inc(32'(err_cnt), ERR_MAX));
    // Count as it will stand after this SAMPLE, so the final vector is reflected in pass.
    assign err_after = mismatch ? err_next : err_cnt;

    tt_step_timer #(
        .N_IN (N_IN),
        .HOLD (HOLD)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .hold_en    (hold_en),
        .advance    (advance),
        .vec        (vec_out),
        .sample_now (sample_now),
        .last_vec   (last_vec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            tt_a    <= '0;
            tt_b    <= '0;
`ifdef TT_FIRST_FAIL_EN
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_cnt <= '0;
                        pass    <= 1'b0;
                        tt_a    <= '0;
                        tt_b    <= '0;
                        busy    <= 1'b1;
                        state   <= ST_APPLY;
`ifdef TT_FIRST_FAIL_EN
                        first_fail_vld <= 1'b0;
                        first_fail_vec <= '0;
`endif
                    end
                end
                ST_APPLY: begin
                    if (sample_now) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    tt_a[vec_out] <= dut_a;
                    tt_b[vec_out] <= dut_b;
                    err_cnt       <= err_after;
`ifdef TT_FIRST_FAIL_EN
                    if (mismatch && !first_fail_vld) begin
                        first_fail_vld <= 1'b1;
                        first_fail_vec <= vec_out;
                    end
`endif
                    if (last_vec) begin
                        done  <= 1'b1;
                        pass  <= (err_after == '0);
                        state <= ST_DONE;
                    end else begin
                        state <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - randomized self-checking bench for truth_table_sequencer
module tb_truth_table_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int tests = 0;
    int fails = 0;

    // dut0: N_IN=2, HOLD=1, CNT_W=8
    logic       start0, mode0;
    logic [3:0] exp0, fa0, fb0;
    logic       a0, b0;
    logic [1:0] vec0;
    logic       busy0, done0, pass0;
    logic [7:0] err0;
    logic [3:0] tta0, ttb0;
    assign a0 = fa0[vec0];
    assign b0 = fb0[vec0];

    // dut1: HOLD=3
    logic       start1;
    logic       mode1 = 1'b0;
    logic [3:0] exp1 = 4'b0000;
    logic       a1, b1;
    logic [1:0] vec1;
    logic       busy1, done1, pass1;
    logic [7:0] err1;
    logic [3:0] tta1, ttb1;
    assign a1 = fa0[vec1];
    assign b1 = fb0[vec1];

    // dut2: CNT_W=1, dut_a tied low
    logic       start2;
    logic       mode2 = 1'b1;
    logic [3:0] exp2 = 4'b1111;
    logic       a2 = 1'b0;
    logic       b2 = 1'b0;
    logic [1:0] vec2;
    logic       busy2, done2, pass2;
    logic [0:0] err2;
    logic [3:0] tta2, ttb2;

`ifdef TT_FIRST_FAIL_EN
    logic       ffv0, ffv1, ffv2;
    logic [1:0] ffvec0, ffvec1, ffvec2;
`endif

    truth_table_sequencer #(.N_IN(2), .HOLD(1), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .cmp_mode(mode0), .exp_tt(exp0),
        .dut_a(a0), .dut_b(b0), .vec_out(vec0), .busy(busy0), .done(done0),
        .pass(pass0), .err_cnt(err0),
`ifdef TT_FIRST_FAIL_EN
        .first_fail_vld(ffv0), .first_fail_vec(ffvec0),
`endif
        .tt_a(tta0), .tt_b(ttb0));

    truth_table_sequencer #(.N_IN(2), .HOLD(3), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .cmp_mode(mode1), .exp_tt(exp1),
        .dut_a(a1), .dut_b(b1), .vec_out(vec1), .busy(busy1), .done(done1),
        .pass(pass1), .err_cnt(err1),
`ifdef TT_FIRST_FAIL_EN
        .first_fail_vld(ffv1), .first_fail_vec(ffvec1),
`endif
        .tt_a(tta1), .tt_b(ttb1));

    truth_table_sequencer #(.N_IN(2), .HOLD(1), .CNT_W(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .cmp_mode(mode2), .exp_tt(exp2),
        .dut_a(a2), .dut_b(b2), .vec_out(vec2), .busy(busy2), .done(done2),
        .pass(pass2), .err_cnt(err2),
`ifdef TT_FIRST_FAIL_EN
        .first_fail_vld(ffv2), .first_fail_vec(ffvec2),
`endif
        .tt_a(tta2), .tt_b(ttb2));

    // Gate behaviour as a table: sel 0 -> ~x & y, sel 1 -> ~x & ~y (x = MSB of vector).
    function automatic logic [3:0] gate_tab(input int sel);
        logic [3:0] t;
        for (int i = 0; i < 4; i++) begin
            int x = (i >> 1) & 1;
            int y = i & 1;
            t[i] = (sel == 0) ? ((x == 0) && (y == 1)) : ((x == 0) && (y == 0));
        end
        return t;
    endfunction

    function automatic int model_err(input logic [3:0] fa, input logic [3:0] fb,
                                     input logic mode, input logic [3:0] ex, input int maxv);
        int n = 0;
        for (int i = 0; i < 4; i++)
            if (fa[i] != (mode ? ex[i] : fb[i])) n++;
        return (n > maxv) ? maxv : n;
    endfunction

    function automatic int model_first(input logic [3:0] fa, input logic [3:0] fb,
                                       input logic mode, input logic [3:0] ex);
        for (int i = 0; i < 4; i++)
            if (fa[i] != (mode ? ex[i] : fb[i])) return i;
        return -1;
    endfunction

    // Pulse start on dut0 and return the spec cycle number at which done is seen (-1 on timeout).
    task automatic sweep0(output int done_cyc);
        int t0;
        @(negedge clk);
        start0 = 1'b1;
        t0 = edge_n + 1;
        @(negedge clk);
        start0 = 1'b0;
        done_cyc = -1;
        for (int k = 0; k < 100; k++) begin
            if (done0) begin
                done_cyc = edge_n - t0 + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        mode0 = 1'b0; exp0 = 4'b0; fa0 = 4'b0; fb0 = 4'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (vec0 !== 2'b0)  begin fails++; $display("FAIL reset_vec got=%0h want=0", vec0); end
        tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy got=%0b want=0", busy0); end
        tests++; if (done0 !== 1'b0) begin fails++; $display("FAIL reset_done got=%0b want=0", done0); end
        tests++; if (pass0 !== 1'b0) begin fails++; $display("FAIL reset_pass got=%0b want=0", pass0); end
        tests++; if (err0 !== 8'd0)  begin fails++; $display("FAIL reset_err got=%0d want=0", err0); end
        tests++; if ({tta0, ttb0} !== 8'h00) begin fails++; $display("FAIL reset_tt got=%0h want=0", {tta0, ttb0}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_case1;
        int dc;
        fa0 = gate_tab(0); fb0 = gate_tab(1); mode0 = 1'b0; exp0 = 4'b0;
        sweep0(dc);
        tests++; if (dc !== 9)          begin fails++; $display("FAIL c1_done_cycle got=%0d want=9", dc); end
        tests++; if (tta0 !== 4'b0010)  begin fails++; $display("FAIL c1_tt_a got=%b want=0010", tta0); end
        tests++; if (ttb0 !== 4'b0001)  begin fails++; $display("FAIL c1_tt_b got=%b want=0001", ttb0); end
        tests++; if (err0 !== 8'd2)     begin fails++; $display("FAIL c1_err got=%0d want=2", err0); end
        tests++; if (busy0 !== 1'b1)    begin fails++; $display("FAIL c1_busy_in_done got=%0b want=1", busy0); end
`ifdef TT_FIRST_FAIL_EN
        tests++; if ({ffv0, ffvec0} !== 3'b100) begin fails++; $display("FAIL c1_first_fail got=%b want=100", {ffv0, ffvec0}); end
`endif
        @(negedge clk);
        tests++; if (pass0 !== 1'b0)    begin fails++; $display("FAIL c1_pass got=%0b want=0", pass0); end
        tests++; if (busy0 !== 1'b0)    begin fails++; $display("FAIL c1_busy_after got=%0b want=0", busy0); end
        tests++; if (vec0 !== 2'b00)    begin fails++; $display("FAIL c1_vec_after got=%0h want=0", vec0); end
        tests++; if (done0 !== 1'b0)    begin fails++; $display("FAIL c1_done_width got=%0b want=0", done0); end
    endtask

    task automatic test_cmp_mode;
        int dc;
        fa0 = gate_tab(0); fb0 = gate_tab(1); mode0 = 1'b1; exp0 = 4'b0010;
        sweep0(dc);
        tests++; if (err0 !== 8'd0) begin fails++; $display("FAIL c2_err_golden got=%0d want=0", err0); end
        @(negedge clk);
        tests++; if (pass0 !== 1'b1) begin fails++; $display("FAIL c2_pass_golden got=%0b want=1", pass0); end
        exp0 = 4'b0011;
        sweep0(dc);
        tests++; if (err0 !== 8'd1) begin fails++; $display("FAIL c2_err_one got=%0d want=1", err0); end
        @(negedge clk);
        tests++; if (pass0 !== 1'b0) begin fails++; $display("FAIL c2_pass_one got=%0b want=0", pass0); end
    endtask

    task automatic test_hold3;
        int t0;
        int dc;
        int bad;
        logic [1:0] seen[$];
        fa0 = gate_tab(0); fb0 = gate_tab(1);
        @(negedge clk);
        start1 = 1'b1;
        t0 = edge_n + 1;
        @(negedge clk);
        start1 = 1'b0;
        dc = -1;
        for (int k = 0; k < 100; k++) begin
            if (done1) begin
                dc = edge_n - t0 + 1;
                break;
            end
            seen.push_back(vec1);
            @(negedge clk);
        end
        bad = 0;
        for (int k = 0; k < seen.size(); k++)
            if (seen[k] != 2'(k / 4)) bad++;
        tests++; if (dc !== 17) begin fails++; $display("FAIL c3_done_cycle got=%0d want=17", dc); end
        tests++; if (seen.size() !== 16 || bad != 0) begin fails++; $display("FAIL c3_vec_hold got=%0d samples/%0d bad want=16/0", seen.size(), bad); end
        tests++; if (err1 !== 8'd2) begin fails++; $display("FAIL c3_err got=%0d want=2", err1); end
        @(negedge clk);
    endtask

    task automatic test_extra_start;
        int t0;
        int c;
        int dn;
        int first;
        fa0 = gate_tab(0); fb0 = gate_tab(1); mode0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        t0 = edge_n + 1;
        dn = 0;
        first = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            c = edge_n - t0 + 1;
            start0 = (c == 4 || c == 6);
            if (done0) begin
                dn++;
                if (first < 0) first = c;
            end
        end
        start0 = 1'b0;
        tests++; if (dn !== 1)     begin fails++; $display("FAIL c4_done_pulses got=%0d want=1", dn); end
        tests++; if (first !== 9)  begin fails++; $display("FAIL c4_done_cycle got=%0d want=9", first); end
        tests++; if (err0 !== 8'd2) begin fails++; $display("FAIL c4_err got=%0d want=2", err0); end
    endtask

    task automatic test_reset_mid;
        int t0;
        int dn;
        int dc;
        fa0 = gate_tab(0); fb0 = gate_tab(1); mode0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        t0 = edge_n + 1;
        @(negedge clk);
        start0 = 1'b0;
        while (edge_n - t0 + 1 < 5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL c5_busy got=%0b want=0", busy0); end
        tests++; if (vec0 !== 2'b00) begin fails++; $display("FAIL c5_vec got=%0h want=0", vec0); end
        tests++; if (err0 !== 8'd0)  begin fails++; $display("FAIL c5_err got=%0d want=0", err0); end
        tests++; if (tta0 !== 4'b0)  begin fails++; $display("FAIL c5_tt_a got=%b want=0000", tta0); end
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            if (done0) dn++;
            @(negedge clk);
        end
        tests++; if (dn !== 0) begin fails++; $display("FAIL c5_no_done got=%0d want=0", dn); end
        sweep0(dc);
        tests++; if (dc !== 9 || tta0 !== 4'b0010 || ttb0 !== 4'b0001 || err0 !== 8'd2) begin
            fails++;
            $display("FAIL c5_fresh got=cyc%0d a%b b%b e%0d want=cyc9 a0010 b0001 e2", dc, tta0, ttb0, err0);
        end
        @(negedge clk);
    endtask

    task automatic test_saturate;
        int t0;
        int dc;
        @(negedge clk);
        start2 = 1'b1;
        t0 = edge_n + 1;
        @(negedge clk);
        start2 = 1'b0;
        dc = -1;
        for (int k = 0; k < 100; k++) begin
            if (done2) begin
                dc = edge_n - t0 + 1;
                break;
            end
            @(negedge clk);
        end
        tests++; if (dc !== 9) begin fails++; $display("FAIL c6_done_cycle got=%0d want=9", dc); end
        tests++; if (err2 !== 1'(model_err(4'b0000, 4'b0000, 1'b1, 4'b1111, 1))) begin
            fails++; $display("FAIL c6_err_sat got=%0d want=1", err2);
        end
        @(negedge clk);
        tests++; if (pass2 !== 1'b0) begin fails++; $display("FAIL c6_pass got=%0b want=0", pass2); end
    endtask

    task automatic test_start_held;
        int t0;
        int c;
        int d[$];
        fa0 = gate_tab(0); fb0 = gate_tab(1); mode0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        t0 = edge_n + 1;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            c = edge_n - t0 + 1;
            if (done0) d.push_back(c);
        end
        start0 = 1'b0;
        tests++; if (d.size() !== 2 || d[0] != 9 || d[1] != 19) begin
            fails++;
            $display("FAIL held_start got=%0d pulses first=%0d second=%0d want=2/9/19", d.size(),
                     (d.size() > 0) ? d[0] : -1, (d.size() > 1) ? d[1] : -1);
        end
        for (int k = 0; k < 40 && busy0; k++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_random;
        int dc;
        int we;
        for (int n = 0; n < 10; n++) begin
            fa0   = 4'($urandom);
            fb0   = 4'($urandom);
            mode0 = 1'($urandom);
            exp0  = 4'($urandom);
            sweep0(dc);
            we = model_err(fa0, fb0, mode0, exp0, 255);
            tests++; if (dc !== 9 || tta0 !== fa0 || ttb0 !== fb0 || err0 !== 8'(we)) begin
                fails++;
                $display("FAIL rand%0d got=cyc%0d a%b b%b e%0d want=cyc9 a%b b%b e%0d",
                         n, dc, tta0, ttb0, err0, fa0, fb0, we);
            end
`ifdef TT_FIRST_FAIL_EN
            tests++; if (ffv0 !== (model_first(fa0, fb0, mode0, exp0) >= 0) ||
                         (ffv0 && int'(ffvec0) != model_first(fa0, fb0, mode0, exp0))) begin
                fails++; $display("FAIL rand%0d_first got=%b/%0d want=%0d", n, ffv0, ffvec0,
                                  model_first(fa0, fb0, mode0, exp0));
            end
`endif
            @(negedge clk);
            tests++; if (pass0 !== (we == 0)) begin
                fails++; $display("FAIL rand%0d_pass got=%0b want=%0b", n, pass0, (we == 0));
            end
        end
    endtask

    initial begin
        test_reset;
        test_case1;
        test_cmp_mode;
        test_hold3;
        test_extra_start;
        test_reset_mid;
        test_saturate;
        test_start_held;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
